commit_monitor: RTL and testbench

// - Multi-lane retirement monitor between the mp4 writeback/commit stage(s) and the RVFI/shadow-memory checkers.
// - Assigns the RVFI instruction order to up to NUM_CH commits per cycle, for superscalar or OoO retire.
// - Detects halt (a control-flow instruction that jumps to itself, committed HALT_REPEAT times in a row).
// - Detects a no-commit watchdog timeout.

---
 rtl/commit_monitor.sv | 204 ++++++++++++++++++++
 tb/tb_commit_monitor.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/commit_monitor.sv
// Multi-lane retirement monitor: assigns RVFI order to each commit lane, detects halt (self-loop) and no-commit timeout.
// Optional statistics (per-lane commit counts, longest idle gap) are built only when MONITOR_STATS_EN is defined.
module commit_monitor #(
  parameter int NUM_CH         = 2,
  parameter int XLEN           = 32,
  parameter int ORDER_W        = 64,
  parameter int HALT_REPEAT    = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic [NUM_CH-1:0]         commit_valid,
  input  logic [NUM_CH-1:0]         commit_is_ctrl,
  input  logic [NUM_CH*XLEN-1:0]    commit_pc_rdata,
  input  logic [NUM_CH*XLEN-1:0]    commit_pc_wdata,
  output logic [NUM_CH*ORDER_W-1:0] commit_order,
  output logic                      halt,
  output logic                      timeout,
  output logic [ORDER_W-1:0]        total_commits,
  output logic [NUM_CH*32-1:0]      lane_commits,
  output logic [31:0]               max_idle_gap
);

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_HALTED  = 2'd1;
  localparam logic [1:0] ST_TIMEOUT = 2'd2;

  localparam int               HCW       = $clog2(HALT_REPEAT + 1);
  localparam logic [HCW-1:0]   HALT_MAX  = HCW'(HALT_REPEAT);
  localparam logic [HCW-1:0]   HALT_ONE  = HCW'(1);
  localparam logic [31:0]      IDLE_LAST = 32'(TIMEOUT_CYCLES - 1);
  localparam logic [31:0]      CNT_MAX   = 32'hFFFF_FFFF;

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [ORDER_W-1:0] order_base_r;
  logic [HCW-1:0]     halt_cnt_r;
  logic [HCW-1:0]     halt_cnt_nxt_s;
  logic               halt_hit_s;
  logic [31:0]        idle_cnt_r;
  logic [31:0]        idle_inc_s;
  logic               run_s;
  logic               any_commit_s;
  logic               idle_expire_s;
  logic [NUM_CH-1:0]  accept_s;
  logic [ORDER_W-1:0] commit_count_s;

  // Number of set bits among the lanes strictly below 'upto'.
  function automatic logic [ORDER_W-1:0] count_ones(input logic [NUM_CH-1:0] bits, input int upto);
    logic [ORDER_W-1:0] cnt;
    cnt = {ORDER_W{1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      if (i < upto && bits[i]) begin
        cnt = cnt + ORDER_W'(1);
      end
    end
    return cnt;
  endfunction

  function automatic logic is_self_loop(input logic ctrl, input logic [XLEN-1:0] pc_r, input logic [XLEN-1:0] pc_w);
    return ctrl && (pc_r == pc_w);
  endfunction

  assign run_s          = (state_r == ST_RUN);
  assign accept_s       = commit_valid & {NUM_CH{run_s}};
  assign any_commit_s   = |accept_s;
  assign commit_count_s = count_ones(accept_s, NUM_CH);
  assign idle_inc_s     = (idle_cnt_r != CNT_MAX) ? idle_cnt_r + 32'd1 : idle_cnt_r;
  assign idle_expire_s  = run_s && !any_commit_s && (idle_cnt_r == IDLE_LAST);
  assign total_commits  = order_base_r;

  // Per-lane order: base plus the number of accepted commits in older lanes.
  always_comb begin
    commit_order = {(NUM_CH*ORDER_W){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      commit_order[i*ORDER_W +: ORDER_W] = order_base_r + count_ones(accept_s, i);
    end
  end

  // Oldest-to-youngest scan of self-loop commits; any other commit restarts the run.
  always_comb begin
    halt_cnt_nxt_s = halt_cnt_r;
    halt_hit_s     = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (accept_s[i]) begin
        if (is_self_loop(commit_is_ctrl[i], commit_pc_rdata[i*XLEN +: XLEN], commit_pc_wdata[i*XLEN +: XLEN])) begin
          if (halt_cnt_nxt_s != HALT_MAX) begin
            halt_cnt_nxt_s = halt_cnt_nxt_s + HALT_ONE;
          end else begin
            halt_cnt_nxt_s = halt_cnt_nxt_s;
          end
          if (halt_cnt_nxt_s == HALT_MAX) begin
            halt_hit_s = 1'b1;
          end else begin
            halt_hit_s = halt_hit_s;
          end
        end else begin
          halt_cnt_nxt_s = {HCW{1'b0}};
        end
      end else begin
        halt_cnt_nxt_s = halt_cnt_nxt_s;
      end
    end
  end

  // Next-state: halt takes priority over timeout; terminal states only leave on reset/clear.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (halt_hit_s) begin
          state_nxt_s = ST_HALTED;
        end else if (idle_expire_s) begin
          state_nxt_s = ST_TIMEOUT;
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_HALTED:  state_nxt_s = ST_HALTED;
      ST_TIMEOUT: state_nxt_s = ST_TIMEOUT;
      default:    state_nxt_s = ST_RUN;
    endcase
  end

  // Core state, order base and counters; frozen outside RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_RUN;
      halt         <= 1'b0;
      timeout      <= 1'b0;
      order_base_r <= {ORDER_W{1'b0}};
      halt_cnt_r   <= {HCW{1'b0}};
      idle_cnt_r   <= 32'd0;
    end else if (clear) begin
      state_r      <= ST_RUN;
      halt         <= 1'b0;
      timeout      <= 1'b0;
      order_base_r <= {ORDER_W{1'b0}};
      halt_cnt_r   <= {HCW{1'b0}};
      idle_cnt_r   <= 32'd0;
    end else begin
      state_r <= state_nxt_s;
      halt    <= (state_nxt_s == ST_HALTED);
      timeout <= (state_nxt_s == ST_TIMEOUT);
      if (run_s) begin
        order_base_r <= order_base_r + commit_count_s;
        halt_cnt_r   <= halt_cnt_nxt_s;
        idle_cnt_r   <= any_commit_s ? 32'd0 : idle_inc_s;
      end else begin
        order_base_r <= order_base_r;
        halt_cnt_r   <= halt_cnt_r;
        idle_cnt_r   <= idle_cnt_r;
      end
    end
  end

`ifdef MONITOR_STATS_EN
  logic [31:0] lane_cnt_r [NUM_CH];
  logic [31:0] max_idle_r;

  // Saturating per-lane commit counters and longest idle run seen in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lane_cnt_r[i] <= 32'd0;
      end
      max_idle_r <= 32'd0;
    end else if (clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        lane_cnt_r[i] <= 32'd0;
      end
      max_idle_r <= 32'd0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (accept_s[i] && lane_cnt_r[i] != CNT_MAX) begin
          lane_cnt_r[i] <= lane_cnt_r[i] + 32'd1;
        end else begin
          lane_cnt_r[i] <= lane_cnt_r[i];
        end
      end
      if (run_s && !any_commit_s && idle_inc_s > max_idle_r) begin
        max_idle_r <= idle_inc_s;
      end else begin
        max_idle_r <= max_idle_r;
      end
    end
  end

  // Flatten the lane counters onto the output bus.
  always_comb begin
    lane_commits = {(NUM_CH*32){1'b0}};
    for (int i = 0; i < NUM_CH; i++) begin
      lane_commits[i*32 +: 32] = lane_cnt_r[i];
    end
  end

  assign max_idle_gap = max_idle_r;
`else
  assign lane_commits = {(NUM_CH*32){1'b0}};
  assign max_idle_gap = 32'd0;
`endif

endmodule

// File: tb/tb_commit_monitor.sv
// Scoreboard bench for commit_monitor: driver pushes model expectations, negedge monitor pops and compares.
module tb_commit_monitor;
  localparam int NUM_CH = 2;
  localparam int XLEN   = 32;
  localparam int OW     = 4;
  localparam int HR     = 2;
  localparam int TO     = 10;

  logic                   clk = 1'b0;
  logic                   reset = 1'b0;
  logic                   clear = 1'b0;
  logic [NUM_CH-1:0]      commit_valid = '0;
  logic [NUM_CH-1:0]      commit_is_ctrl = '0;
  logic [NUM_CH*XLEN-1:0] commit_pc_rdata = '0;
  logic [NUM_CH*XLEN-1:0] commit_pc_wdata = '0;
  logic [NUM_CH*OW-1:0]   commit_order;
  logic                   halt, timeout;
  logic [OW-1:0]          total_commits;
  logic [NUM_CH*32-1:0]   lane_commits;
  logic [31:0]            max_idle_gap;

  commit_monitor #(.NUM_CH(NUM_CH), .XLEN(XLEN), .ORDER_W(OW), .HALT_REPEAT(HR), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .commit_valid(commit_valid), .commit_is_ctrl(commit_is_ctrl),
    .commit_pc_rdata(commit_pc_rdata), .commit_pc_wdata(commit_pc_wdata),
    .commit_order(commit_order), .halt(halt), .timeout(timeout),
    .total_commits(total_commits), .lane_commits(lane_commits), .max_idle_gap(max_idle_gap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  v;
    logic        chk1;
    logic [31:0] ord0, ord1, h, t, tot, lc0, lc1, mig;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0;
  int n_bad = 0;

  // reference model: 0=RUN 1=HALTED 2=TIMEOUT
  int m_state, m_base, m_hc, m_idle, m_max;
  int m_lc[2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_state = 0; m_base = 0; m_hc = 0; m_idle = 0; m_max = 0;
    m_lc[0] = 0; m_lc[1] = 0;
  endtask

  // Drive one cycle, push the expected observation, then advance the model past the next edge.
  task automatic step(input logic rst_v, input logic clr, input logic [1:0] v, input logic [1:0] ctrl,
                      input logic [31:0] pr0, input logic [31:0] pw0, input logic [31:0] pr1, input logic [31:0] pw1);
    exp_t e;
    int n, cnt;
    bit hit, expire;
    logic [31:0] pr[2], pw[2];
    @(posedge clk); #1;
    reset = rst_v; clear = clr; commit_valid = v; commit_is_ctrl = ctrl;
    commit_pc_rdata = {pr1, pr0}; commit_pc_wdata = {pw1, pw0};
    pr[0] = pr0; pr[1] = pr1; pw[0] = pw0; pw[1] = pw1;
    if (!rst_v) m_reset();
    e.v    = v;
    e.chk1 = (v[1] || m_state != 0) ? 1'b1 : 1'b0;
    e.ord0 = m_base;
    e.ord1 = (m_base + ((m_state == 0 && v[0]) ? 1 : 0)) % 16;
    e.h    = (m_state == 1) ? 1 : 0;
    e.t    = (m_state == 2) ? 1 : 0;
    e.tot  = m_base;
    e.lc0  = m_lc[0]; e.lc1 = m_lc[1]; e.mig = m_max;
    q.push_back(e);
    if (!rst_v || clr) begin
      m_reset();
    end else if (m_state == 0) begin
      n = 0; hit = 0; cnt = m_hc;
      for (int i = 0; i < 2; i++) begin
        if (v[i]) begin
          n++; m_lc[i]++;
          if (ctrl[i] && pr[i] == pw[i]) begin
            cnt = (cnt < HR) ? cnt + 1 : HR;
            if (cnt == HR) hit = 1;
          end else cnt = 0;
        end
      end
      m_hc = cnt;
      m_base = (m_base + n) % 16;
      if (n == 0) begin
        expire = (m_idle == TO - 1);
        m_idle++;
        if (m_idle > m_max) m_max = m_idle;
      end else begin
        expire = 0; m_idle = 0;
      end
      if (hit) m_state = 1;
      else if (expire) m_state = 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic lane0(input logic ctrl, input logic [31:0] pr, input logic [31:0] pw);
    step(1'b1, 1'b0, 2'b01, {1'b0, ctrl}, pr, pw, 32'h0, 32'h0);
  endtask

  task automatic do_clear();
    step(1'b1, 1'b1, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  // Monitor: compare every cycle the driver produced an expectation for.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("halt", {31'd0, halt}, e.h);
      chk("timeout", {31'd0, timeout}, e.t);
      chk("total_commits", {28'd0, total_commits}, e.tot);
      chk("order_lane0", {28'd0, commit_order[3:0]}, e.ord0);
      if (e.chk1) chk("order_lane1", {28'd0, commit_order[7:4]}, e.ord1);
`ifdef MONITOR_STATS_EN
      chk("lane_commits0", lane_commits[31:0], e.lc0);
      chk("lane_commits1", lane_commits[63:32], e.lc1);
      chk("max_idle_gap", max_idle_gap, e.mig);
`endif
    end
  end

  initial begin
    logic [1:0] v, c;
    logic [31:0] a0, b0, a1, b1;
    m_reset();
    // T1 reset held then idle
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    idle(5);
    // T2 order sequence
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b11, 2'b00, 32'h10, 32'h14, 32'h14, 32'h18);
    step(1'b1, 1'b0, 2'b10, 2'b00, 32'h0, 32'h0, 32'h20, 32'h24);
    step(1'b1, 1'b0, 2'b01, 2'b00, 32'h24, 32'h28, 32'h0, 32'h0);
    idle(1);
    // T3 halt with gap, then interleave that must not halt
    do_clear();
    lane0(1'b1, 32'h60, 32'h60); idle(1); lane0(1'b1, 32'h60, 32'h60);
    idle(3);
    do_clear();
    lane0(1'b1, 32'h60, 32'h60); lane0(1'b1, 32'h60, 32'h64); lane0(1'b1, 32'h60, 32'h60);
    idle(2);
    // T4 same-cycle halt, then frozen counters
    do_clear();
    step(1'b1, 1'b0, 2'b11, 2'b11, 32'h80, 32'h80, 32'h80, 32'h80);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 2'b11, 2'b00, 32'h0, 32'h4, 32'h4, 32'h8);
    // T5 timeout boundary
    do_clear();
    idle(TO - 1); lane0(1'b0, 32'h0, 32'h4);
    idle(TO + 3);
    do_clear(); idle(2);
    // T6 wrap
    for (int i = 0; i < 17; i++) lane0(1'b0, 32'h100, 32'h104);
    // async reset mid-run, checked between edges
    @(negedge clk); #1;
    commit_valid = 2'b00; reset = 1'b0; #1;
    chk("async_halt", {31'd0, halt}, 32'd0);
    chk("async_timeout", {31'd0, timeout}, 32'd0);
    chk("async_total", {28'd0, total_commits}, 32'd0);
    chk("async_order", {24'd0, commit_order}, 32'd0);
    m_reset();
    step(1'b0, 1'b0, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    // randomized traffic with occasional clears
    for (int i = 0; i < 600; i++) begin
      v  = ($urandom_range(0, 9) < 4) ? 2'b00 : 2'($urandom_range(0, 3));
      c  = 2'($urandom_range(0, 3));
      a0 = 32'h200 + 32'($urandom_range(0, 3)) * 32'd4;
      a1 = 32'h200 + 32'($urandom_range(0, 3)) * 32'd4;
      b0 = ($urandom_range(0, 1) == 1) ? a0 : a0 + 32'd4;
      b1 = ($urandom_range(0, 1) == 1) ? a1 : a1 + 32'd4;
      step(1'b1, ($urandom_range(0, 24) == 0) ? 1'b1 : 1'b0, v, c, a0, b0, a1, b1);
    end
    idle(2);
    @(negedge clk); #2;
    chk("scoreboard_drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
